// File: rtl/bbox_pkg.sv
// Shared types and result-field layout for the bounding-box tracker.
// Optional BBOX_TRACKER_AREA_EN adds a foreground pixel count output.
package bbox_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_REPORT = 2'd2
    } bbox_state_e;

    // Result word is {found, xmin, ymin, xmax, ymax}, MSB first.
    function automatic int res_width(input int xw, input int yw);
        return 1 + 2 * xw + 2 * yw;
    endfunction

    function automatic int found_pos(input int xw, input int yw);
        return 2 * xw + 2 * yw;
    endfunction

    function automatic int xmin_lsb(input int xw, input int yw);
        return xw + 2 * yw;
    endfunction

    function automatic int ymin_lsb(input int xw, input int yw);
        return xw + yw;
    endfunction

    function automatic int xmax_lsb(input int xw, input int yw);
        return yw + 0 * xw;
    endfunction

    localparam int YMAX_LSB = 0;

endpackage

// File: rtl/bbox_coord_counter.sv
// Column/row position of the current beat; SOF forces (0,0), EOL wraps
// the column and advances the row, the column saturates without EOL.
module bbox_coord_counter #(
    parameter int X_WIDTH      = 11,
    parameter int Y_WIDTH      = 11,
    parameter int FRAME_HEIGHT = 480
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_beat,
    input  logic               i_sof,
    input  logic               i_eol,
    output logic [X_WIDTH-1:0] o_x,
    output logic [Y_WIDTH-1:0] o_y,
    output logic               o_last
);

    localparam logic [X_WIDTH-1:0] X_MAX = '1;
    localparam logic [Y_WIDTH-1:0] Y_LAST = Y_WIDTH'(FRAME_HEIGHT - 1);

    logic [X_WIDTH-1:0] x_q;
    logic [Y_WIDTH-1:0] y_q;

    assign o_x    = i_sof ? '0 : x_q;
    assign o_y    = i_sof ? '0 : y_q;
    assign o_last = i_eol && (o_y == Y_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            x_q <= '0;
            y_q <= '0;
        end else if (i_beat) begin
            if (i_eol) begin
                x_q <= '0;
                y_q <= o_y + Y_WIDTH'(1);
            end else begin
                x_q <= (o_x == X_MAX) ? o_x : o_x + X_WIDTH'(1);
                y_q <= o_y;
            end
        end
    end

endmodule

// File: rtl/bbox_tracker.sv
// Bounding box of above-threshold pixels over one video frame.
// Define BBOX_TRACKER_AREA_EN to add the o_area foreground pixel count.
module bbox_tracker
    import bbox_pkg::*;
#(
    parameter int TDATA_WIDTH  = 8,
    parameter int X_WIDTH      = 11,
    parameter int Y_WIDTH      = 11,
    parameter int FRAME_HEIGHT = 480
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic                                 i_tvalid,
    output logic                                 o_tready,
    input  logic [TDATA_WIDTH-1:0]               i_tdata,
    input  logic                                 i_tuser,
    input  logic                                 i_tlast,
    input  logic [TDATA_WIDTH-1:0]               i_threshold,
    output logic                                 o_tvalid,
    input  logic                                 i_tready,
    output logic [1+2*X_WIDTH+2*Y_WIDTH-1:0]     o_tdata,
    output logic                                 o_resync
`ifdef BBOX_TRACKER_AREA_EN
    ,
    output logic [X_WIDTH+Y_WIDTH-1:0]           o_area
`endif
);

    localparam int RW     = res_width(X_WIDTH, Y_WIDTH);
    localparam int F_POS  = found_pos(X_WIDTH, Y_WIDTH);
    localparam int XMIN_L = xmin_lsb(X_WIDTH, Y_WIDTH);
    localparam int YMIN_L = ymin_lsb(X_WIDTH, Y_WIDTH);
    localparam int XMAX_L = xmax_lsb(X_WIDTH, Y_WIDTH);

    bbox_state_e            state_q;
    logic [TDATA_WIDTH-1:0] thr_q;
    logic                   found_q, found_n, base_found;
    logic [X_WIDTH-1:0]     xmin_q, xmax_q, xmin_n, xmax_n;
    logic [Y_WIDTH-1:0]     ymin_q, ymax_q, ymin_n, ymax_n;
    logic [X_WIDTH-1:0]     cur_x;
    logic [Y_WIDTH-1:0]     cur_y;
    logic                   last;
    logic                   accept, beat, fg;
    logic [RW-1:0]          res;

    // o_tready is zero in REPORT, so nothing is accepted there.
    assign accept = i_tvalid && o_tready;
    assign beat   = accept && (state_q == S_ACTIVE || i_tuser);
    assign fg     = i_tdata >= (i_tuser ? i_threshold : thr_q);

    bbox_coord_counter #(
        .X_WIDTH      (X_WIDTH),
        .Y_WIDTH      (Y_WIDTH),
        .FRAME_HEIGHT (FRAME_HEIGHT)
    ) u_coord (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_beat (beat),
        .i_sof  (i_tuser),
        .i_eol  (i_tlast),
        .o_x    (cur_x),
        .o_y    (cur_y),
        .o_last (last)
    );

    always_comb begin
        base_found = i_tuser ? 1'b0 : found_q;
        found_n    = base_found;
        xmin_n     = i_tuser ? '0 : xmin_q;
        xmax_n     = i_tuser ? '0 : xmax_q;
        ymin_n     = i_tuser ? '0 : ymin_q;
        ymax_n     = i_tuser ? '0 : ymax_q;
        if (beat && fg) begin
            found_n = 1'b1;
            if (!base_found) begin
                xmin_n = cur_x;
                xmax_n = cur_x;
                ymin_n = cur_y;
                ymax_n = cur_y;
            end else begin
                if (cur_x < xmin_n) xmin_n = cur_x;
                if (cur_x > xmax_n) xmax_n = cur_x;
                if (cur_y < ymin_n) ymin_n = cur_y;
                if (cur_y > ymax_n) ymax_n = cur_y;
            end
        end
        res                       = '0;
        res[F_POS]                = found_n;
        res[XMIN_L +: X_WIDTH]    = xmin_n;
        res[YMIN_L +: Y_WIDTH]    = ymin_n;
        res[XMAX_L +: X_WIDTH]    = xmax_n;
        res[YMAX_LSB +: Y_WIDTH]  = ymax_n;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            thr_q    <= '0;
            found_q  <= 1'b0;
            xmin_q   <= '0;
            xmax_q   <= '0;
            ymin_q   <= '0;
            ymax_q   <= '0;
            o_tready <= 1'b0;
            o_tvalid <= 1'b0;
            o_tdata  <= '0;
            o_resync <= 1'b0;
        end else begin
            o_resync <= beat && i_tuser && (state_q == S_ACTIVE);
            case (state_q)
                S_IDLE, S_ACTIVE: begin
                    o_tready <= 1'b1;
                    if (beat) begin
                        if (i_tuser) thr_q <= i_threshold;
                        state_q <= S_ACTIVE;
                        found_q <= found_n;
                        xmin_q  <= xmin_n;
                        xmax_q  <= xmax_n;
                        ymin_q  <= ymin_n;
                        ymax_q  <= ymax_n;
                        if (last) begin
                            state_q  <= S_REPORT;
                            o_tready <= 1'b0;
                            o_tvalid <= 1'b1;
                            o_tdata  <= res;
                            found_q  <= 1'b0;
                            xmin_q   <= '0;
                            xmax_q   <= '0;
                            ymin_q   <= '0;
                            ymax_q   <= '0;
                        end
                    end
                end
                S_REPORT: begin
                    if (i_tready) begin
                        state_q  <= S_IDLE;
                        o_tvalid <= 1'b0;
                        o_tready <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef BBOX_TRACKER_AREA_EN
    localparam int AW = X_WIDTH + Y_WIDTH;
    localparam logic [AW-1:0] A_MAX = '1;

    logic [AW-1:0] area_q, area_base, area_n;

    always_comb begin
        area_base = i_tuser ? '0 : area_q;
        area_n    = area_base;
        if (beat && fg && area_base != A_MAX) area_n = area_base + AW'(1);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            area_q <= '0;
            o_area <= '0;
        end else if (state_q != S_REPORT && beat) begin
            area_q <= last ? '0 : area_n;
            if (last) o_area <= area_n;
        end
    end
`endif

endmodule
